zuc_dw_pack: RTL

// - Parametrised width up-converter for the ZUC keystream/data path.
// - Packs RATIO consecutive W-bit input words into one RATIO*W-bit output beat.
// - A short final group (s_last before RATIO words) is flushed as a zero-padded

---
 rtl/zuc_dw_pack.sv | 93 +++++++++
 1 files changed

// File: rtl/zuc_dw_pack.sv
// Width up-converter: packs RATIO W-bit words into one registered output beat.
// Short final groups flush zero-padded, with a per-word keep mask.
module zuc_dw_pack #(
    parameter int W     = 32,
    parameter int RATIO = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               s_valid,
    output logic               s_ready,
    input  logic               s_last,
    input  logic [W-1:0]       s_data,
    output logic               m_valid,
    input  logic               m_ready,
    output logic               m_last,
    output logic [RATIO-1:0]   m_keep,
    output logic [RATIO*W-1:0] m_data
);
    localparam int IW = (RATIO > 1) ? $clog2(RATIO) : 1;

    logic [IW-1:0]      idx_q, idx_d;
    logic [RATIO*W-1:0] acc_q, acc_d;
    logic [RATIO*W-1:0] data_q, data_d;
    logic [RATIO-1:0]   keep_q, keep_d;
    logic               last_q, last_d;
    logic               valid_q, valid_d;

    logic               take;
    logic               done;
    logic [RATIO*W-1:0] slot;
    logic [RATIO-1:0]   kmask;

    assign s_ready = !valid_q || m_ready;
    assign take    = s_valid && s_ready;
    assign done    = s_last || (idx_q == IW'(RATIO - 1));

    // Slots above idx are always zero in acc, so OR-ing in the new word
    // yields the zero-padded beat directly.
    always_comb begin
        slot  = '0;
        kmask = '0;
        for (int k = 0; k < RATIO; k++) begin
            if (IW'(k) == idx_q) slot[W*(RATIO-k)-1 -: W] = s_data;
            if (IW'(k) <= idx_q) kmask[RATIO-1-k] = 1'b1;
        end
    end

    always_comb begin
        idx_d   = idx_q;
        acc_d   = acc_q;
        data_d  = data_q;
        keep_d  = keep_q;
        last_d  = last_q;
        valid_d = valid_q;
        if (m_ready) valid_d = 1'b0;
        if (take) begin
            if (done) begin
                data_d  = acc_q | slot;
                keep_d  = kmask;
                last_d  = s_last;
                valid_d = 1'b1;
                idx_d   = '0;
                acc_d   = '0;
            end else begin
                acc_d = acc_q | slot;
                idx_d = idx_q + IW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q   <= '0;
            acc_q   <= '0;
            data_q  <= '0;
            keep_q  <= '0;
            last_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            idx_q   <= idx_d;
            acc_q   <= acc_d;
            data_q  <= data_d;
            keep_q  <= keep_d;
            last_q  <= last_d;
            valid_q <= valid_d;
        end
    end

    assign m_valid = valid_q;
    assign m_last  = last_q;
    assign m_keep  = keep_q;
    assign m_data  = data_q;
endmodule
